// File: rtl/tmr_scrub_regfile.sv
// Triplicated 32x32 register file with 2-of-3 voted reads and a background scrubber.
// Reads are combinational; the scrubber checks one register per cycle (plus SCRUB_GAP idle cycles).
module tmr_scrub_regfile #(
    parameter int CNT_W     = 8,
    parameter int SCRUB_GAP = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [4:0]       wa3,
    input  logic [31:0]      wd3,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [31:0]      rd1,
    output logic [31:0]      rd2,
    input  logic             scrub_en,
    input  logic             inj_en,
    input  logic [1:0]       inj_copy,
    input  logic [4:0]       inj_addr,
    input  logic [4:0]       inj_bit,
    output logic [CNT_W-1:0] fault_count,
    output logic             fault_flag,
    output logic [4:0]       err_addr,
    output logic [4:0]       scrub_addr
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_REPAIR = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    localparam int GAP_W = (SCRUB_GAP > 1) ? $clog2(SCRUB_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((SCRUB_GAP > 0) ? SCRUB_GAP - 1 : 0);
    localparam logic [1:0] S_AFTER = (SCRUB_GAP > 0) ? S_WAIT : S_CHECK;

    logic [31:0]      cp [3][32];
    logic [1:0]       state;
    logic [GAP_W-1:0] gap_cnt;

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : maj(cp[0][ra1], cp[1][ra1], cp[2][ra1]);
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : maj(cp[0][ra2], cp[1][ra2], cp[2][ra2]);

    logic        scrub_mismatch;
    logic [31:0] repair_val;
    logic        repair_wr;
    logic        inj_hit;
    logic [4:0]  scrub_next;

    assign scrub_mismatch = (cp[0][scrub_addr] != cp[1][scrub_addr]) ||
                            (cp[0][scrub_addr] != cp[2][scrub_addr]);
    assign repair_val     = maj(cp[0][err_addr], cp[1][err_addr], cp[2][err_addr]);
    // A functional write to the register under repair carries newer data than the vote.
    assign repair_wr      = (state == S_REPAIR) && !(we3 && wa3 == err_addr);
    assign inj_hit        = inj_en && (inj_copy != 2'd3) && (inj_addr != 5'd0) &&
                            !(we3 && wa3 == inj_addr);
    assign scrub_next     = (scrub_addr == 5'd31) ? 5'd1 : scrub_addr + 5'd1;

    // Entry 0 of every copy is never written, so it stays zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < 32; a++)
                    cp[k][a] <= 32'd0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                for (int a = 1; a < 32; a++) begin
                    if (we3 && wa3 == a[4:0])
                        cp[k][a] <= wd3;
                    else if (repair_wr && err_addr == a[4:0])
                        cp[k][a] <= repair_val;
                    else if (inj_hit && inj_addr == a[4:0] && inj_copy == k[1:0])
                        cp[k][a] <= cp[k][a] ^ (32'd1 << inj_bit);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            scrub_addr  <= 5'd1;
            err_addr    <= 5'd0;
            fault_count <= '0;
            fault_flag  <= 1'b0;
        end else begin
            fault_flag <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (scrub_en)
                        state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!scrub_en) begin
                        state <= S_IDLE;
                    end else if (scrub_mismatch) begin
                        err_addr <= scrub_addr;
                        state    <= S_REPAIR;
                    end else begin
                        scrub_addr <= scrub_next;
                        gap_cnt    <= '0;
                        state      <= S_AFTER;
                    end
                end
                S_REPAIR: begin
                    if (fault_count != {CNT_W{1'b1}})
                        fault_count <= fault_count + CNT_W'(1);
                    fault_flag <= 1'b1;
                    scrub_addr <= scrub_next;
                    gap_cnt    <= '0;
                    state      <= S_AFTER;
                end
                S_WAIT: begin
                    if (!scrub_en) begin
                        state <= S_IDLE;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmr_scrub_regfile.sv
// Bench for tmr_scrub_regfile: three instances (default, CNT_W=2, SCRUB_GAP=2) share one stimulus.
module tb_tmr_scrub_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1, ra2;
    logic        scrub_en;
    logic        inj_en;
    logic [1:0]  inj_copy;
    logic [4:0]  inj_addr, inj_bit;

    logic [31:0] rd1, rd2, rd1_b, rd2_b, rd1_c, rd2_c;
    logic [7:0]  fault_count;
    logic [1:0]  fault_count_b;
    logic [7:0]  fault_count_c;
    logic        fault_flag, fault_flag_b, fault_flag_c;
    logic [4:0]  err_addr, err_addr_b, err_addr_c;
    logic [4:0]  scrub_addr, scrub_addr_b, scrub_addr_c;

    always #5 clk = ~clk;

    tmr_scrub_regfile dut (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .scrub_en(scrub_en), .inj_en(inj_en), .inj_copy(inj_copy),
        .inj_addr(inj_addr), .inj_bit(inj_bit), .fault_count(fault_count),
        .fault_flag(fault_flag), .err_addr(err_addr), .scrub_addr(scrub_addr)
    );

    tmr_scrub_regfile #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b), .rd2(rd2_b), .scrub_en(scrub_en), .inj_en(inj_en), .inj_copy(inj_copy),
        .inj_addr(inj_addr), .inj_bit(inj_bit), .fault_count(fault_count_b),
        .fault_flag(fault_flag_b), .err_addr(err_addr_b), .scrub_addr(scrub_addr_b)
    );

    tmr_scrub_regfile #(.SCRUB_GAP(2)) dut3 (
        .clk(clk), .reset(reset), .we3(we3), .wa3(wa3), .wd3(wd3), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_c), .rd2(rd2_c), .scrub_en(scrub_en), .inj_en(inj_en), .inj_copy(inj_copy),
        .inj_addr(inj_addr), .inj_bit(inj_bit), .fault_count(fault_count_c),
        .fault_flag(fault_flag_c), .err_addr(err_addr_c), .scrub_addr(scrub_addr_c)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t        vecs [6];
    logic [31:0] sb_q [$];
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_copies(input string nm, input int a, input logic [31:0] exp);
        for (int k = 0; k < 3; k++)
            check($sformatf("%s_copy%0d", nm, k), dut.cp[k][a], exp);
    endtask

    task automatic inject(input logic [1:0] c, input logic [4:0] a, input logic [4:0] b);
        inj_en = 1'b1; inj_copy = c; inj_addr = a; inj_bit = b;
        @(negedge clk);
        inj_en = 1'b0;
    endtask

    task automatic stop_scrub();
        scrub_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses, pulses_b;
        logic [31:0] seen;
        logic        found;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hFFFFFFFF};
        vecs[4] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd1,  32'hDEADBEEF, 32'h00000001};
        vecs[5] = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd31, 32'h12345678, 32'h12345678};

        reset = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = 5'd5; ra2 = 5'd0;
        scrub_en = 1'b0; inj_en = 1'b0; inj_copy = '0; inj_addr = '0; inj_bit = '0;
        #12 reset = 1'b0;
        @(negedge clk);
        check("rst_fault_count", 32'(fault_count), 32'd0);
        check("rst_fault_flag", 32'(fault_flag), 32'd0);
        check("rst_err_addr", 32'(err_addr), 32'd0);
        check("rst_scrub_addr", 32'(scrub_addr), 32'd1);
        check("rst_rd1", rd1, 32'd0);

        // Write/read table: expectations are queued at drive time, compared one edge later.
        for (int i = 0; i < 6; i++) begin
            we3 = vecs[i].we; wa3 = vecs[i].wa; wd3 = vecs[i].wd;
            ra1 = vecs[i].r1; ra2 = vecs[i].r2;
            sb_q.push_back(vecs[i].e1);
            sb_q.push_back(vecs[i].e2);
            @(negedge clk);
            check($sformatf("vec%0d_rd1", i), rd1, sb_q.pop_front());
            check($sformatf("vec%0d_rd2", i), rd2, sb_q.pop_front());
        end
        we3 = 1'b0;
        check("t1_fault_count", 32'(fault_count), 32'd0);

        // Write and injection on the same register in one cycle: the write wins.
        we3 = 1'b1; wa3 = 5'd9; wd3 = 32'hCAFEF00D;
        inject(2'd0, 5'd9, 5'd0);
        we3 = 1'b0;
        check_copies("coll_inj", 9, 32'hCAFEF00D);
        inject(2'd3, 5'd9, 5'd1);
        check_copies("inj_copy3", 9, 32'hCAFEF00D);
        inject(2'd1, 5'd0, 5'd2);
        check("inj_r0", dut.cp[1][0], 32'd0);

        // Single-copy fault repaired by the scrubber; reads stay correct throughout.
        ra1 = 5'd5;
        inject(2'd1, 5'd5, 5'd3);
        check("t2_copy1_corrupt", dut.cp[1][5], 32'hDEADBEE7);
        scrub_en = 1'b1;
        pulses = 0; seen = 32'hDEADBEEF;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fault_flag) pulses++;
            if (rd1 !== 32'hDEADBEEF && seen === 32'hDEADBEEF) seen = rd1;
        end
        check("t2_rd1_stable", seen, 32'hDEADBEEF);
        check("t2_pulses", 32'(pulses), 32'd1);
        check("t2_err_addr", 32'(err_addr), 32'd5);
        check("t2_fault_count", 32'(fault_count), 32'd1);
        check_copies("t2_r5", 5, 32'hDEADBEEF);
        stop_scrub();

        // Same bit flipped in two copies: the vote follows the majority.
        inject(2'd0, 5'd5, 5'd3);
        inject(2'd2, 5'd5, 5'd3);
        check("t3_rd1_voted", rd1, 32'hDEADBEE7);
        scrub_en = 1'b1;
        repeat (40) @(negedge clk);
        check_copies("t3_r5", 5, 32'hDEADBEE7);
        check("t3_fault_count", 32'(fault_count), 32'd2);
        stop_scrub();

        // Functional write lands during the REPAIR cycle of the same register.
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h11111111;
        @(negedge clk);
        we3 = 1'b0;
        inject(2'd2, 5'd7, 5'd4);
        scrub_en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            if (err_addr == 5'd7) found = 1'b1;
        end
        check("t4_repair_seen", 32'(found), 32'd1);
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'hA5A5A5A5;
        @(negedge clk);
        we3 = 1'b0;
        check("t4_flag", 32'(fault_flag), 32'd1);
        check_copies("t4_r7", 7, 32'hA5A5A5A5);
        check("t4_fault_count", 32'(fault_count), 32'd3);
        stop_scrub();

        // Five separate faults: the 2-bit counter saturates, every repair still pulses.
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        inject(2'd0, 5'd10, 5'd0);
        inject(2'd1, 5'd11, 5'd31);
        inject(2'd2, 5'd12, 5'd15);
        inject(2'd0, 5'd13, 5'd7);
        inject(2'd1, 5'd14, 5'd20);
        scrub_en = 1'b1;
        pulses = 0; pulses_b = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (fault_flag) pulses++;
            if (fault_flag_b) pulses_b++;
        end
        check("t5_sat_count", 32'(fault_count_b), 32'd3);
        check("t5_sat_pulses", 32'(pulses_b), 32'd5);
        check("t5_wide_count", 32'(fault_count), 32'd5);
        check_copies("t5_r14", 14, 32'd0);
        stop_scrub();

        // Reset asserted while a repair is in flight.
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h0F0F0F0F;
        @(negedge clk);
        we3 = 1'b0;
        inject(2'd0, 5'd3, 5'd9);
        scrub_en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(negedge clk);
            if (err_addr == 5'd3) found = 1'b1;
        end
        check("t6_repair_seen", 32'(found), 32'd1);
        ra1 = 5'd3; ra2 = 5'd5;
        reset = 1'b1;
        #2;
        scrub_en = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("t6_rd1", rd1, 32'd0);
        check("t6_rd2", rd2, 32'd0);
        check("t6_fault_count", 32'(fault_count), 32'd0);
        check("t6_fault_flag", 32'(fault_flag), 32'd0);
        check("t6_scrub_addr", 32'(scrub_addr), 32'd1);
        check("t6_state", 32'(dut.state), 32'd0);
        check_copies("t6_r3", 3, 32'd0);

        // Clean sweep: gap 0 advances every cycle and wraps 31 -> 1; gap 2 every third cycle.
        scrub_en = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            sb_q.push_back(32'(((k - 1) % 31) + 1));
            sb_q.push_back(32'(1 + (k + 1) / 3));
            @(negedge clk);
            check($sformatf("sweep_gap0_k%0d", k), 32'(scrub_addr), sb_q.pop_front());
            check($sformatf("sweep_gap2_k%0d", k), 32'(scrub_addr_c), sb_q.pop_front());
        end
        check("sweep_no_faults", 32'(fault_count), 32'd0);
        scrub_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
